// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-client SDRAM arbiter.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 32;

    localparam logic OWNER_VID = 1'b0;
    localparam logic OWNER_CPU = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_V = 2'd1,
        BUSY_C = 2'd2
    } state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter in front of sdram_master: video reads have priority,
// the CPU engine is guaranteed a slot after STARVE_MAX contested video grants.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              m_read_req,
    output logic              m_write_req,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_write_data,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_data,
    output logic              owner,
    output logic              timeout_err
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic                grant_v, grant_c;
    logic                vid_eff, cpu_eff;
    logic                starve_full, timeout_hit;
    logic [STARVE_W-1:0] starve_cnt;
    logic [TO_W-1:0]     timeout_cnt;

    // A client whose ack is showing this cycle sits out one arbitration round.
    assign vid_eff     = vid_req & ~vid_ack_q;
    assign cpu_eff     = cpu_req & ~cpu_ack_q;
    assign starve_full = (starve_cnt == STARVE_W'(STARVE_MAX));
    assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT));

    arb_sat_counter #(.WIDTH(STARVE_W), .MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_v & cpu_eff),
        .clr   (grant_c),
        .count (starve_cnt)
    );

    arb_sat_counter #(.WIDTH(TO_W), .MAX(TIMEOUT)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q != IDLE),
        .clr   (grant_v | grant_c),
        .count (timeout_cnt)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        owner_d       = owner_q;
        vid_ack_d     = 1'b0;
        cpu_ack_d     = 1'b0;
        timeout_err_d = 1'b0;
        vid_data_d    = vid_data_q;
        cpu_rdata_d   = cpu_rdata_q;
        grant_v       = 1'b0;
        grant_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_eff && starve_full) begin
                    grant_c = 1'b1;
                end else if (vid_eff) begin
                    grant_v = 1'b1;
                end else if (cpu_eff) begin
                    grant_c = 1'b1;
                end
                if (grant_v) begin
                    state_d = BUSY_V;
                    addr_d  = vid_addr;
                    we_d    = 1'b0;
                    owner_d = OWNER_VID;
                end else if (grant_c) begin
                    state_d = BUSY_C;
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    owner_d = OWNER_CPU;
                end
            end
            // Completion takes precedence over a coincident timeout.
            BUSY_V: begin
                if (m_ready) begin
                    state_d    = IDLE;
                    vid_ack_d  = 1'b1;
                    vid_data_d = m_data;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            BUSY_C: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    cpu_ack_d = 1'b1;
                    if (!we_q) begin
                        cpu_rdata_d = m_data;
                    end
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            owner_q       <= 1'b0;
            vid_ack_q     <= 1'b0;
            cpu_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            vid_data_q    <= '0;
            cpu_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            owner_q       <= owner_d;
            vid_ack_q     <= vid_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            timeout_err_q <= timeout_err_d;
            vid_data_q    <= vid_data_d;
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

    assign m_read_req   = (state_q == BUSY_V) | ((state_q == BUSY_C) & ~we_q);
    assign m_write_req  = (state_q == BUSY_C) & we_q;
    assign m_address    = addr_q;
    assign m_write_data = wdata_q;
    assign vid_ack      = vid_ack_q;
    assign cpu_ack      = cpu_ack_q;
    assign vid_data     = vid_data_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign owner        = owner_q;
    assign timeout_err  = timeout_err_q;

endmodule
